// File: rtl/jtag_shift_seq.sv
// JTAG buffer sequencer: turns single host commands (shift, reset pulse, bus release)
// into TCK/TMS/TDI waveforms with a programmable TCK divider and returns captured TDO.
module jtag_shift_seq #(
  parameter int DIV_W        = 8,
  parameter int PULSE_CYCLES = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [4:0]       CMD_LEN,
  input  logic [31:0]      CMD_TMS,
  input  logic [31:0]      CMD_TDI,
  input  logic [DIV_W-1:0] CLK_DIV,
  output logic             RSP_VALID,
  output logic [31:0]      RSP_TDO,
  output logic             BUSY,
  output logic             TCK,
  output logic             TMS,
  output logic             TDI,
  input  logic             TDO,
  output logic             JTAG_OE,
  output logic             nSRST_OUT,
  output logic             nTRST_OUT
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_PULSE, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [4:0]       r_len, r_bit;
  logic [31:0]      r_tms, r_tdi, r_tdo;
  logic [DIV_W-1:0] r_d, r_div;
  logic [PW-1:0]    r_pcnt;
  logic             r_tck, r_tms_o, r_tdi_o, r_oe, r_nsrst, r_ntrst;
  logic             w_accept, w_div_end, w_last_bit, w_pulse_end;

  always_comb begin
    w_accept    = CMD_VALID && (r_state == S_IDLE);
    w_div_end   = (r_div == r_d);
    w_last_bit  = (r_bit == r_len);
    w_pulse_end = (r_pcnt == PLAST);
    w_next      = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = (CMD_OP == 2'b00) ? S_LOW : S_PULSE;
      S_LOW:   if (w_div_end) w_next = S_HIGH;
      S_HIGH:  if (w_div_end) w_next = w_last_bit ? S_DONE : S_LOW;
      S_PULSE: if (w_pulse_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_len   <= '0;
      r_bit   <= '0;
      r_tms   <= '0;
      r_tdi   <= '0;
      r_tdo   <= '0;
      r_d     <= '0;
      r_div   <= '0;
      r_pcnt  <= '0;
      r_tck   <= 1'b0;
      r_tms_o <= 1'b1;
      r_tdi_o <= 1'b0;
      r_oe    <= 1'b1;
      r_nsrst <= 1'b1;
      r_ntrst <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_len  <= CMD_LEN;
          r_tms  <= CMD_TMS;
          r_tdi  <= CMD_TDI;
          r_d    <= CLK_DIV;
          r_div  <= '0;
          r_bit  <= '0;
          r_tdo  <= '0;
          // Release reuses PULSE as a single-cycle wait by preloading the terminal count
          r_pcnt <= (CMD_OP == 2'b11) ? PLAST : '0;
          unique case (CMD_OP)
            2'b00: begin
              r_oe    <= 1'b0;
              r_tck   <= 1'b0;
              r_tms_o <= CMD_TMS[0];
              r_tdi_o <= CMD_TDI[0];
            end
            2'b01: r_nsrst <= 1'b0;
            2'b10: r_ntrst <= 1'b0;
            default: begin
              r_oe  <= 1'b1;
              r_tck <= 1'b0;
            end
          endcase
        end
        S_LOW: begin
          if (w_div_end) begin
            r_div        <= '0;
            r_tck        <= 1'b1;
            r_tdo[r_bit] <= TDO;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_HIGH: begin
          if (w_div_end) begin
            r_div <= '0;
            r_tck <= 1'b0;
            if (!w_last_bit) begin
              r_bit   <= r_bit + 5'd1;
              r_tms_o <= r_tms[r_bit + 5'd1];
              r_tdi_o <= r_tdi[r_bit + 5'd1];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_PULSE: begin
          if (w_pulse_end) begin
            r_nsrst <= 1'b1;
            r_ntrst <= 1'b1;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign CMD_READY = (r_state == S_IDLE);
  assign BUSY      = (r_state != S_IDLE);
  assign RSP_VALID = (r_state == S_DONE);
  assign RSP_TDO   = r_tdo;
  assign TCK       = r_tck;
  assign TMS       = r_tms_o;
  assign TDI       = r_tdi_o;
  assign JTAG_OE   = r_oe;
  assign nSRST_OUT = r_nsrst;
  assign nTRST_OUT = r_ntrst;

endmodule

// File: doc/jtag_shift_seq.md
Name: jtag_shift_seq

Overview:
Sequencer that drives the JTAG buffer lines (TCK/TMS/TDI, output enable, nSRST/nTRST) from an on-chip command interface, replacing direct pin-level bit-banging.
It accepts one command at a time: a shift of 1–32 bits, a reset pulse, or a bus release.
For shifts it generates TCK with a programmable divider, captures TDO, and returns the captured bits in a one-cycle response.
It sits between the host command logic and the JTAG pin buffers.

Parameters:
DIV_W, 8, width of CLK_DIV
PULSE_CYCLES, 1000, length in CLK cycles of an nSRST/nTRST low pulse (≥1)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
CMD_VALID  input  1  command offered
CMD_READY  output  1  sequencer can accept; high only in IDLE
CMD_OP  input  2  00 shift, 01 nSRST pulse, 10 nTRST pulse, 11 release bus
CMD_LEN  input  5  shift bit count minus 1 (0..31 → 1..32 bits)
CMD_TMS  input  32  TMS bits, LSB shifted first
CMD_TDI  input  32  TDI bits, LSB shifted first
CLK_DIV  input  DIV_W  TCK half-period = CLK_DIV+1 CLK cycles; sampled at accept
RSP_VALID  output  1  one-cycle pulse on command completion
RSP_TDO  output  32  captured TDO, bit i = i-th shifted bit, unused upper bits 0
BUSY  output  1  high whenever state ≠ IDLE
TCK, TMS, TDI  output  1  JTAG drive to buffer
TDO  input  1  JTAG return from target
JTAG_OE  output  1  buffer enable, active low (1 = TCK/TMS/TDI tristated)
nSRST_OUT, nTRST_OUT  output  1  reset drives, active low

Behaviour:
- Reset values (RST high at a CLK edge, any state): state IDLE; TCK=0; TMS=1; TDI=0; JTAG_OE=1; nSRST_OUT=1; nTRST_OUT=1; RSP_VALID=0; RSP_TDO=0; BUSY=0; CMD_READY=1 from the cycle after reset. Reset mid-operation aborts immediately with no RSP_VALID.
- Accept: the cycle in which CMD_VALID&CMD_READY. Latch OP, LEN, TMS, TDI, and D=CLK_DIV. CMD_VALID while not ready is ignored; there is no queueing.
- States: IDLE, LOW, HIGH, PULSE, DONE.
- Shift (OP 00):
  - JTAG_OE←0 on accept and stays 0 after completion.
  - Bit index i=0. Enter LOW: TCK=0, TMS=CMD_TMS[i], TDI=CMD_TDI[i], held for D+1 cycles.
  - On the CLK edge leaving LOW, TCK←1 and RSP_TDO[i]←TDO (value present in the last LOW cycle).
  - HIGH lasts D+1 cycles. If i<LEN: i←i+1, go to LOW. Else: TCK←0, go to DONE. TMS/TDI hold the last bit values after completion.
- Pulse (OP 01/10): go to PULSE. The selected nSRST_OUT/nTRST_OUT is 0 for exactly PULSE_CYCLES cycles, then 1, then DONE. RSP_TDO=0. JTAG lines unchanged.
- Release (OP 11): JTAG_OE←1, TCK←0, then DONE next cycle. RSP_TDO=0.
- DONE: RSP_VALID=1 for exactly one cycle, then IDLE. CMD_READY=0 in DONE, so the earliest next accept is the cycle after RSP_VALID.
- Latency:
  - Shift of N bits with accept at cycle 0: RSP_VALID in cycle 1+2N(D+1).
  - Pulse: RSP_VALID in cycle 1+PULSE_CYCLES.
  - Release: RSP_VALID in cycle 2.
- Divider counter is DIV_W bits, counts 0..D, and never wraps past D. D=0 gives a TCK period of 2 CLK.
- RSP_TDO is held stable from RSP_VALID until the next accepted shift. It is cleared to 0 at each shift accept.

Test Plan:
- Reset: assert RST for 2 cycles mid-shift (LEN=31, D=3) → next cycle TCK=0, TMS=1, JTAG_OE=1, BUSY=0, no RSP_VALID; CMD_READY=1.
- Loopback shift: TDO tied to TDI, CMD_LEN=3, CMD_TDI=0xA, CMD_TMS=0x8, CLK_DIV=0, accept at cycle 0 → TMS sequence 0,0,0,1 with TCK period 2 cycles; RSP_VALID at cycle 9; RSP_TDO=0x0000000A; JTAG_OE=0 from cycle 1.
- Divider: CLK_DIV=2, LEN=0, TDO=1 → TCK low 3 cycles then high 3 cycles; RSP_VALID at cycle 7; RSP_TDO=0x1.
- Full width: LEN=31, TDI=0xDEADBEEF loopback, D=0 → 32 rising TCK edges; RSP_TDO=0xDEADBEEF; RSP_VALID at cycle 65.
- Pulse: PULSE_CYCLES=1000, OP=01 → nSRST_OUT low for exactly 1000 cycles, nTRST_OUT stays 1; RSP_VALID at cycle 1001. CMD_VALID pulses during BUSY are ignored (no second pulse).
- Release after shift: OP=11 → JTAG_OE=1 in cycle 1; RSP_VALID in cycle 2; a back-to-back shift is accepted the cycle after RSP_VALID and drives JTAG_OE=0 again.
